dmem_port_arbiter: RTL and testbench

//  Shares one data memory (32-bit word array, 4-bit byte-write enable, 1-cycle synchronous read)

---
 rtl/dmem_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Two-port data-memory arbiter: round-robin between CPU (port 0) and DMA/debug (port 1).
// Latency: gnt is combinational in IDLE; store/error done at gnt+1, load done at gnt+2.
// Backpressure: requesters hold req until gnt; a new grant is issued only from IDLE.
module dmem_port_arbiter #(
   parameter int DM_ADDRESS = 9,
   parameter int DATA_W     = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [1:0]            req,
   input  logic [1:0]            we,
   input  logic [DM_ADDRESS-1:0] addr0,
   input  logic [DM_ADDRESS-1:0] addr1,
   input  logic [DATA_W-1:0]     wd0,
   input  logic [DATA_W-1:0]     wd1,
   input  logic [2:0]            funct3_0,
   input  logic [2:0]            funct3_1,
   output logic [1:0]            gnt,
   output logic [1:0]            done,
   output logic [1:0]            err,
   output logic [DATA_W-1:0]     rd,
   output logic [DM_ADDRESS-1:0] mem_addr,
   output logic [DATA_W-1:0]     mem_wd,
   output logic [3:0]            mem_wr,
   input  logic [DATA_W-1:0]     mem_rd
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_RESP   = 2'd2;

   logic [1:0]            state;
   logic [1:0]            state_nxt;
   logic                  last;      // port granted most recently
   logic                  pick;      // port chosen this cycle
   logic                  cap_port;
   logic                  cap_we;
   logic [DM_ADDRESS-1:0] cap_addr;
   logic [DATA_W-1:0]     cap_wd;
   logic [2:0]            cap_f3;
   logic [1:0]            off;
   logic                  illegal;
   logic                  fin;
   logic [15:0]           sel;
   logic [DATA_W-1:0]     load_val;
   logic [DATA_W-1:0]     rd_q;

   assign off      = cap_addr[1:0];
   assign mem_addr = {cap_addr[DM_ADDRESS-1:2], 2'b00};

   // Round-robin pick: a lone requester wins, a tie goes to the port not granted last
   always_comb begin
      pick = 1'b0;
      gnt  = 2'b00;
      if (state == S_IDLE && req != 2'b00) begin
         if (req == 2'b11) pick = ~last;
         else              pick = req[1];
         gnt = pick ? 2'b10 : 2'b01;
      end
   end

   // Access legality: unknown sizes and misaligned halfword/word accesses are rejected
   always_comb begin
      case (cap_f3)
         3'b000, 3'b100: illegal = 1'b0;
         3'b001, 3'b101: illegal = off[0];
         3'b010:         illegal = (off != 2'b00);
         default:        illegal = 1'b1;
      endcase
   end

   // Store lane placement: data replicated across lanes, enables only on a legal store's ACCESS cycle
   always_comb begin
      mem_wr = 4'b0000;
      case (cap_f3[1:0])
         2'b00:   mem_wd = {4{cap_wd[7:0]}};
         2'b01:   mem_wd = {2{cap_wd[15:0]}};
         default: mem_wd = cap_wd;
      endcase
      if (state == S_ACCESS && cap_we && !illegal) begin
         case (cap_f3[1:0])
            2'b00:   mem_wr = 4'b0001 << off;
            2'b01:   mem_wr = off[1] ? 4'b1100 : 4'b0011;
            default: mem_wr = 4'b1111;
         endcase
      end
   end

   // Load alignment and sign/zero extension of the addressed byte/halfword
   assign sel = 16'(mem_rd >> {off, 3'b000});
   always_comb begin
      case (cap_f3)
         3'b000:  load_val = {{16{sel[7]}}, {8{sel[7]}}, sel[7:0]};
         3'b100:  load_val = {24'd0, sel[7:0]};
         3'b001:  load_val = {{16{sel[15]}}, sel[15:0]};
         3'b101:  load_val = {16'd0, sel[15:0]};
         default: load_val = mem_rd;
      endcase
   end

   // Load result is live during RESP and held afterwards
   assign rd = (state == S_RESP) ? load_val : rd_q;

   // Completion pulses go to the port that owns the current access
   always_comb begin
      done = 2'b00;
      err  = 2'b00;
      fin  = (state == S_ACCESS && (cap_we || illegal)) || (state == S_RESP);
      if (fin) done[cap_port] = 1'b1;
      if (fin && state == S_ACCESS && illegal) err[cap_port] = 1'b1;
   end

   // Sequencing: IDLE -> ACCESS -> (legal load) RESP -> IDLE
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (req != 2'b00) state_nxt = S_ACCESS;
         S_ACCESS: state_nxt = (!cap_we && !illegal) ? S_RESP : S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // State, round-robin pointer, captured request fields and held load result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         last     <= 1'b1;
         cap_port <= 1'b0;
         cap_we   <= 1'b0;
         cap_addr <= '0;
         cap_wd   <= '0;
         cap_f3   <= 3'b000;
         rd_q     <= '0;
      end else begin
         state <= state_nxt;
         if (gnt != 2'b00) begin
            last     <= pick;
            cap_port <= pick;
            cap_we   <= we[pick];
            cap_addr <= pick ? addr1 : addr0;
            cap_wd   <= pick ? wd1 : wd0;
            cap_f3   <= pick ? funct3_1 : funct3_0;
         end
         if (state == S_RESP) rd_q <= load_val;
      end
   end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed vector table, reset/arbitration
// sequences, and randomized accesses checked against a byte-array reference model.
module tb_dmem_port_arbiter;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [1:0]  req, we;
   logic [8:0]  addr0, addr1;
   logic [31:0] wd0, wd1;
   logic [2:0]  funct3_0, funct3_1;
   logic [1:0]  gnt, done, err;
   logic [31:0] rd, mem_wd, mem_rd;
   logic [8:0]  mem_addr;
   logic [3:0]  mem_wr;

   dmem_port_arbiter #(.DM_ADDRESS(9), .DATA_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .we(we),
      .addr0(addr0), .addr1(addr1), .wd0(wd0), .wd1(wd1),
      .funct3_0(funct3_0), .funct3_1(funct3_1),
      .gnt(gnt), .done(done), .err(err), .rd(rd),
      .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_wr(mem_wr), .mem_rd(mem_rd)
   );

   // Memory with byte enables, 1-cycle read, plus a bench-side preload port
   logic [31:0] mem_w [128];
   logic        pre_en;
   logic [6:0]  pre_idx;
   logic [31:0] pre_val;
   always @(posedge clk) begin
      if (pre_en) mem_w[pre_idx] <= pre_val;
      for (int b = 0; b < 4; b++)
         if (mem_wr[b]) mem_w[mem_addr[8:2]][8*b +: 8] <= mem_wd[8*b +: 8];
      mem_rd <= mem_w[mem_addr[8:2]];
   end

   int errors = 0;
   int checks = 0;

   // Reference state: byte-addressed memory image and the last load result
   logic [7:0]  ref_mem [512];
   logic [31:0] last_rd;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Structural invariants checked every cycle out of reset
   always @(negedge clk) begin
      #2;
      if (rst_n) begin
         checks++;
         if (gnt == 2'b11 || done == 2'b11 || err == 2'b11 ||
             (mem_wr != 4'b0000 && (done == 2'b00 || err != 2'b00))) begin
            errors++;
            $display("FAIL invariant: gnt=%b done=%b err=%b mem_wr=%b", gnt, done, err, mem_wr);
         end
      end
   end

   function automatic int size_of(input logic [2:0] f);
      case (f[1:0])
         2'b00:   return 1;
         2'b01:   return 2;
         default: return 4;
      endcase
   endfunction

   function automatic bit legal(input logic [2:0] f, input int a);
      if (f == 3'b011 || f == 3'b110 || f == 3'b111) return 1'b0;
      return (a % size_of(f)) == 0;
   endfunction

   // Reference: expected completion latency, error, lanes, data and load result
   task automatic model(input logic w, input logic [8:0] a, input logic [31:0] d, input logic [2:0] f,
                        output bit e_err, output int e_lat, output logic [3:0] e_wr,
                        output logic [31:0] e_wd, output logic [31:0] e_rd);
      int n, ai;
      logic [31:0] v;
      n = size_of(f);
      ai = int'(a);
      e_err = !legal(f, ai);
      e_wr = 4'b0000;
      e_rd = last_rd;
      for (int l = 0; l < 4; l++) e_wd[8*l +: 8] = d[8*(l % n) +: 8];
      if (e_err) e_lat = 1;
      else if (w) begin
         e_lat = 1;
         for (int i = 0; i < n; i++) begin
            e_wr[(ai % 4) + i] = 1'b1;
            ref_mem[ai + i] = d[8*i +: 8];
         end
      end else begin
         e_lat = 2;
         v = 32'd0;
         for (int i = 0; i < n; i++) v = v | (32'(ref_mem[ai + i]) << (8*i));
         if (!f[2] && n < 4 && v[8*n-1])
            for (int b = 8*n; b < 32; b++) v[b] = 1'b1;
         e_rd = v;
         last_rd = v;
      end
   endtask

   task automatic preload(input logic [6:0] idx, input logic [31:0] val);
      @(negedge clk);
      pre_en = 1'b1; pre_idx = idx; pre_val = val;
      @(negedge clk);
      pre_en = 1'b0;
      for (int b = 0; b < 4; b++) ref_mem[{idx, 2'b00} + b] = val[8*b +: 8];
   endtask

   // Issue one request on port p and observe three cycles after the grant
   task automatic txn(input int p, input logic w, input logic [8:0] a, input logic [31:0] d,
                      input logic [2:0] f, output int lat, output logic e, output logic [3:0] wr1,
                      output logic [31:0] o_wd, output logic [8:0] ma, output logic [31:0] r,
                      output logic [3:0] wr_other);
      int k;
      @(negedge clk);
      if (p == 0) begin addr0 = a; wd0 = d; funct3_0 = f; end
      else        begin addr1 = a; wd1 = d; funct3_1 = f; end
      we[p] = w; req[p] = 1'b1;
      #1;
      k = 0;
      while (gnt[p] !== 1'b1 && k < 10) begin @(negedge clk); #1; k++; end
      chk("gnt_seen", {31'd0, gnt[p]}, 32'd1);
      lat = -1; e = 1'b0; wr1 = 4'b0; o_wd = 32'd0; ma = 9'd0; r = 32'd0; wr_other = 4'b0;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         req[p] = 1'b0;
         #1;
         if (c == 1) begin wr1 = mem_wr; o_wd = mem_wd; ma = mem_addr; end
         else wr_other = wr_other | mem_wr;
         if (done[p] && lat < 0) begin lat = c; e = err[p]; r = rd; end
      end
   endtask

   typedef struct {
      int          p;
      logic        w;
      logic [8:0]  a;
      logic [31:0] d;
      logic [2:0]  f;
      logic [31:0] pre;
      bit          x_err;
      int          x_lat;
      logic [3:0]  x_wr;
      logic [31:0] x_wd;
      bit          chk_wd;
      logic [31:0] x_rd;
      bit          chk_rd;
   } vec_t;

   vec_t tbl [12];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat, e_lat;
      logic        e;
      bit          e_err;
      logic [3:0]  wr1, wr_other, e_wr;
      logic [31:0] o_wd, r, e_wd, e_rd;
      logic [8:0]  ma, a;
      logic [2:0]  f;
      logic [2:0]  fl [5];
      logic        w;
      int          p, gseq[$];
      bit          pending, order_bad;
      logic [31:0] d;

      tbl[0]  = '{0, 1'b1, 9'h0D, 32'h000000A5, 3'b000, 32'h0,        1'b0, 1, 4'b0010, 32'hA5A5A5A5, 1'b1, 32'h0,        1'b0};
      tbl[1]  = '{1, 1'b0, 9'h06, 32'h0,        3'b001, 32'h80011234, 1'b0, 2, 4'b0000, 32'h0,        1'b0, 32'hFFFF8001, 1'b1};
      tbl[2]  = '{1, 1'b0, 9'h06, 32'h0,        3'b101, 32'h80011234, 1'b0, 2, 4'b0000, 32'h0,        1'b0, 32'h00008001, 1'b1};
      tbl[3]  = '{0, 1'b1, 9'h02, 32'hCAFEF00D, 3'b010, 32'h0,        1'b1, 1, 4'b0000, 32'h0,        1'b0, 32'h00008001, 1'b1};
      tbl[4]  = '{0, 1'b0, 9'h03, 32'h0,        3'b000, 32'h7F000000, 1'b0, 2, 4'b0000, 32'h0,        1'b0, 32'h0000007F, 1'b1};
      tbl[5]  = '{1, 1'b0, 9'h10, 32'h0,        3'b010, 32'hDEADBEEF, 1'b0, 2, 4'b0000, 32'h0,        1'b0, 32'hDEADBEEF, 1'b1};
      tbl[6]  = '{1, 1'b1, 9'h06, 32'h1234BEEF, 3'b001, 32'h0,        1'b0, 1, 4'b1100, 32'hBEEFBEEF, 1'b1, 32'hDEADBEEF, 1'b1};
      tbl[7]  = '{0, 1'b0, 9'h07, 32'h0,        3'b000, 32'h80000000, 1'b0, 2, 4'b0000, 32'h0,        1'b0, 32'hFFFFFF80, 1'b1};
      tbl[8]  = '{1, 1'b0, 9'h08, 32'h0,        3'b011, 32'h11111111, 1'b1, 1, 4'b0000, 32'h0,        1'b0, 32'hFFFFFF80, 1'b1};
      tbl[9]  = '{0, 1'b0, 9'h05, 32'h0,        3'b101, 32'h22222222, 1'b1, 1, 4'b0000, 32'h0,        1'b0, 32'hFFFFFF80, 1'b1};
      tbl[10] = '{0, 1'b0, 9'h01, 32'h0,        3'b100, 32'h0000FF00, 1'b0, 2, 4'b0000, 32'h0,        1'b0, 32'h000000FF, 1'b1};
      tbl[11] = '{1, 1'b1, 9'h0C, 32'h55667788, 3'b110, 32'h0,        1'b1, 1, 4'b0000, 32'h0,        1'b0, 32'h000000FF, 1'b1};
      fl[0] = 3'b000; fl[1] = 3'b001; fl[2] = 3'b010; fl[3] = 3'b100; fl[4] = 3'b101;

      rst_n = 1'b0; req = 2'b00; we = 2'b00; addr0 = '0; addr1 = '0; wd0 = '0; wd1 = '0;
      funct3_0 = '0; funct3_1 = '0; pre_en = 1'b0; pre_idx = '0; pre_val = '0; last_rd = 32'd0;

      // Reset state
      #1;
      chk("rst0_gnt", {30'd0, gnt}, 32'd0);
      chk("rst0_done", {30'd0, done}, 32'd0);
      chk("rst0_err", {30'd0, err}, 32'd0);
      chk("rst0_rd", rd, 32'd0);
      chk("rst0_mem_wr", {28'd0, mem_wr}, 32'd0);
      chk("rst0_mem_addr", {23'd0, mem_addr}, 32'd0);
      chk("rst0_mem_wd", mem_wd, 32'd0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 128; i++) preload(7'(i), $urandom);

      // Reset asserted while a load sits in RESP aborts it
      preload(7'd8, 32'h12345678);
      @(negedge clk);
      addr0 = 9'h20; funct3_0 = 3'b010; we[0] = 1'b0; req[0] = 1'b1;
      #1;
      chk("rstseq_gnt", {30'd0, gnt}, 32'd1);
      @(negedge clk); req[0] = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rstseq_done", {30'd0, done}, 32'd0);
      chk("rstseq_err", {30'd0, err}, 32'd0);
      chk("rstseq_rd", rd, 32'd0);
      chk("rstseq_mem_wr", {28'd0, mem_wr}, 32'd0);
      chk("rstseq_mem_addr", {23'd0, mem_addr}, 32'd0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rstrel_gnt", {30'd0, gnt}, 32'd0);
      @(negedge clk); #1;
      chk("rstrel_done", {30'd0, done}, 32'd0);
      last_rd = 32'd0;

      // Both ports request continuously: grants alternate starting with port 0
      @(negedge clk);
      addr0 = 9'h40; wd0 = 32'h11112222; funct3_0 = 3'b010;
      addr1 = 9'h44; wd1 = 32'h33334444; funct3_1 = 3'b010;
      we = 2'b11; req = 2'b11;
      pending = 1'b0; order_bad = 1'b0;
      for (int c = 0; c < 14; c++) begin
         #1;
         if (done != 2'b00) pending = 1'b0;
         if (gnt != 2'b00) begin
            if (pending) order_bad = 1'b1;
            pending = 1'b1;
            gseq.push_back(gnt == 2'b10 ? 1 : 0);
         end
         @(negedge clk);
      end
      req = 2'b00; we = 2'b00;
      model(1'b1, 9'h40, 32'h11112222, 3'b010, e_err, e_lat, e_wr, e_wd, e_rd);
      model(1'b1, 9'h44, 32'h33334444, 3'b010, e_err, e_lat, e_wr, e_wd, e_rd);
      chk("arb_count", gseq.size(), 32'd7);
      for (int i = 0; i < gseq.size() && i < 7; i++) chk($sformatf("arb_seq%0d", i), gseq[i], i % 2);
      chk("arb_done_before_gnt", {31'd0, order_bad}, 32'd0);
      @(negedge clk); @(negedge clk);

      // Directed vector table
      for (int i = 0; i < 12; i++) begin
         preload(tbl[i].a[8:2], tbl[i].pre);
         model(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].f, e_err, e_lat, e_wr, e_wd, e_rd);
         txn(tbl[i].p, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].f, lat, e, wr1, o_wd, ma, r, wr_other);
         chk($sformatf("vec%0d_lat", i), lat, tbl[i].x_lat);
         chk($sformatf("vec%0d_err", i), {31'd0, e}, {31'd0, tbl[i].x_err});
         chk($sformatf("vec%0d_mem_wr", i), {28'd0, wr1}, {28'd0, tbl[i].x_wr});
         chk($sformatf("vec%0d_mem_addr", i), {23'd0, ma}, {23'd0, tbl[i].a & 9'h1FC});
         chk($sformatf("vec%0d_wr_other", i), {28'd0, wr_other}, 32'd0);
         if (tbl[i].chk_wd) chk($sformatf("vec%0d_mem_wd", i), o_wd, tbl[i].x_wd);
         if (tbl[i].chk_rd) chk($sformatf("vec%0d_rd", i), r, tbl[i].x_rd);
      end

      // Randomized accesses against the reference model
      for (int i = 0; i < 150; i++) begin
         p = $urandom_range(0, 1);
         w = 1'($urandom_range(0, 1));
         f = ($urandom_range(0, 9) < 8) ? fl[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
         a = 9'($urandom_range(0, 511));
         if ($urandom_range(0, 3) != 0) a = a & ~9'(size_of(f) - 1);
         d = $urandom;
         model(w, a, d, f, e_err, e_lat, e_wr, e_wd, e_rd);
         txn(p, w, a, d, f, lat, e, wr1, o_wd, ma, r, wr_other);
         chk($sformatf("rnd%0d_lat", i), lat, e_lat);
         chk($sformatf("rnd%0d_err", i), {31'd0, e}, {31'd0, e_err});
         chk($sformatf("rnd%0d_mem_wr", i), {28'd0, wr1}, {28'd0, e_wr});
         chk($sformatf("rnd%0d_mem_addr", i), {23'd0, ma}, {23'd0, a & 9'h1FC});
         chk($sformatf("rnd%0d_wr_other", i), {28'd0, wr_other}, 32'd0);
         if (w && !e_err) chk($sformatf("rnd%0d_mem_wd", i), o_wd, e_wd);
         chk($sformatf("rnd%0d_rd", i), r, e_rd);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
